// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - screen geometry, pixel record, writer FSM states
// Purpose: shared definitions for the frame-buffer pixel writer.
// Contents: SCR_W/SCR_H screen size, FB_AW address width, COLOR_W colour
//           width, pixel_t {x,y,c}, state_t FSM encodings, lin_addr().
package screen_pkg;

  localparam int SCR_W   = 320;
  localparam int SCR_H   = 240;
  localparam int FB_AW   = 17;
  localparam int COLOR_W = 3;

  typedef struct packed {
    logic [8:0]         x;
    logic [7:0]         y;
    logic [COLOR_W-1:0] c;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // y*320 + x as two shifts and adds, kept at full 17-bit width.
  function automatic logic [FB_AW-1:0] lin_addr(input logic [8:0] x, input logic [7:0] y);
    logic [FB_AW-1:0] w_y;
    w_y = {9'd0, y};
    return (w_y << 8) + (w_y << 6) + {8'd0, x};
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - pixel-in / frame-buffer-out bundle
// Purpose: groups the pixel stream, clear control and frame-buffer write
//          signals of fb_pixel_writer.
// Signals: in_valid/in_ready/in_x/in_y/in_c   pixel stream
//          clear_req/clear_color/clear_done   full-screen clear control
//          fb_we/fb_ready/fb_addr/fb_data     frame-buffer write port
//          drop_count                         off-screen drop counter
// Modports: slave = the writer, master = its environment.
interface fb_pixel_writer_if;
  import screen_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [8:0]         in_x;
  logic [7:0]         in_y;
  logic [COLOR_W-1:0] in_c;
  logic               clear_req;
  logic [COLOR_W-1:0] clear_color;
  logic               clear_done;
  logic               fb_we;
  logic               fb_ready;
  logic [FB_AW-1:0]   fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic [7:0]         drop_count;

  modport slave (
    input  in_valid, in_x, in_y, in_c, clear_req, clear_color, fb_ready,
    output in_ready, clear_done, fb_we, fb_addr, fb_data, drop_count
  );

  modport master (
    output in_valid, in_x, in_y, in_c, clear_req, clear_color, fb_ready,
    input  in_ready, clear_done, fb_we, fb_addr, fb_data, drop_count
  );

endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous DEPTH x pixel_t FIFO
// Purpose: buffers pixels between the draw controllers and the writer's
//          output register.
// Ports: clk; i_flush (sync clear); i_push/i_din write side;
//        i_pop/o_dout read side (o_dout is the head, valid when !o_empty);
//        o_full, o_empty, o_count occupancy.
module pixel_fifo
  import screen_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  pixel_t                 i_din,
  input  logic                   i_pop,
  output pixel_t                 o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pixel_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - commits the pixel stream to the 320x240 frame buffer
// Purpose: FIFO-decoupled pixel writer with off-screen drop, linear address
//          generation and a full-screen clear sequence.
// Ports: clk, reset (sync, active high); bus (fb_pixel_writer_if.slave)
//        carrying the pixel stream, clear control, frame-buffer write port
//        and drop counter.
module fb_pixel_writer
  import screen_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  fb_pixel_writer_if.slave  bus
);

  localparam int               CW        = $clog2(DEPTH) + 1;
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(SCR_W * SCR_H - 1);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_we;
  logic [FB_AW-1:0]   r_addr;
  logic [COLOR_W-1:0] r_data;
  logic [COLOR_W-1:0] r_clr_c;
  logic               r_clear_done;
  logic [7:0]         r_drop;

  pixel_t             w_din;
  pixel_t             w_dout;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_out_free;
  logic               w_onscreen;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_next;

  assign w_din        = {bus.in_x, bus.in_y, bus.in_c};
  assign w_push       = bus.in_valid && r_in_ready;
  // Output register can take a new value when empty or its write completes.
  assign w_out_free   = !r_we || bus.fb_ready;
  assign w_pop        = !w_empty && w_out_free && (r_state == ST_IDLE || r_state == ST_DRAIN);
  assign w_onscreen   = (w_dout.x < 9'(SCR_W)) && (w_dout.y < 8'(SCR_H));
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_flush (reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_clr_c      <= '0;
      r_clear_done <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DRAIN: begin
          if (w_pop && w_onscreen) begin
            r_we   <= 1'b1;
            r_addr <= lin_addr(w_dout.x, w_dout.y);
            r_data <= w_dout.c;
          end else if (w_out_free) begin
            r_we <= 1'b0;
          end
          if (w_pop && !w_onscreen && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
          end
          if (r_state == ST_IDLE) begin
            if (bus.clear_req) begin
              r_state    <= ST_DRAIN;
              r_clr_c    <= bus.clear_color;
              r_in_ready <= 1'b0;
            end else begin
              // in_ready is the registered form of !full, so look at next occupancy.
              r_in_ready <= (w_count_next != CW'(DEPTH));
            end
          end else if (w_empty && !r_we) begin
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // r_addr doubles as the clear counter; r_we is low only before the first write.
          if (!r_we) begin
            r_we   <= 1'b1;
            r_addr <= '0;
            r_data <= r_clr_c;
          end else if (bus.fb_ready) begin
            if (r_addr == LAST_ADDR) begin
              r_we         <= 1'b0;
              r_clear_done <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_addr <= r_addr + FB_AW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.fb_we      = r_we;
  assign bus.fb_addr    = r_addr;
  assign bus.fb_data    = r_data;
  assign bus.clear_done = r_clear_done;
  assign bus.drop_count = r_drop;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - directed self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fb_pixel_writer_if bus ();

  fb_pixel_writer #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_addr(input int x, input int y);
    return 17'(y * 320 + x);
  endfunction

  task automatic test_reset();
    repeat (3) step();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%0h exp=0", bus.in_ready); end
    tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL rst_fb_we got=%0h exp=0", bus.fb_we); end
    tests++; if (bus.fb_addr !== 17'd0) begin fails++; $display("FAIL rst_fb_addr got=%0h exp=0", bus.fb_addr); end
    tests++; if (bus.fb_data !== 3'd0) begin fails++; $display("FAIL rst_fb_data got=%0h exp=0", bus.fb_data); end
    tests++; if (bus.clear_done !== 1'b0) begin fails++; $display("FAIL rst_clear_done got=%0h exp=0", bus.clear_done); end
    tests++; if (bus.drop_count !== 8'd0) begin fails++; $display("FAIL rst_drop got=%0d exp=0", bus.drop_count); end
    reset = 1'b0;
    step();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got=%0h exp=1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.fb_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_x = 9'd10; bus.in_y = 8'd20; bus.in_c = 3'b101;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_ready got=%0h exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL single_n1_we got=%0h exp=0", bus.fb_we); end
    step();
    tests++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd6410 || bus.fb_data !== 3'b101) begin
      fails++; $display("FAIL single_n2 got we=%0h addr=%0d data=%0h exp we=1 addr=6410 data=5", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    step();
    tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL single_n3_we got=%0h exp=0", bus.fb_we); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_a;
    bus.fb_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = (k < 4);
      bus.in_x = 9'(k * 40); bus.in_y = 8'(k * 50 + 1); bus.in_c = 3'(k + 1);
      if (k < 4) begin
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready k=%0d got=%0h exp=1", k, bus.in_ready); end
      end
      if (k >= 2 && k < 6) begin
        exp_a = ref_addr((k - 2) * 40, (k - 2) * 50 + 1);
        tests++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== exp_a || bus.fb_data !== 3'(k - 1)) begin
          fails++; $display("FAIL b2b_write k=%0d got we=%0h addr=%0d data=%0h exp we=1 addr=%0d data=%0h", k, bus.fb_we, bus.fb_addr, bus.fb_data, exp_a, 3'(k - 1));
        end
      end else begin
        tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL b2b_idle k=%0d got we=%0h exp=0", k, bus.fb_we); end
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int   acc;
    int   nw;
    logic took;
    bus.fb_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_x = 9'(acc * 7 + 1); bus.in_y = 8'(acc * 3); bus.in_c = 3'(acc);
      took = bus.in_ready;
      step();
      if (took) acc++;
    end
    bus.in_valid = 1'b0;
    tests++; if (acc !== 9) begin fails++; $display("FAIL bp_accepted got=%0d exp=9", acc); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready got=%0h exp=0", bus.in_ready); end
    tests++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== ref_addr(1, 0) || bus.fb_data !== 3'd0) begin
      fails++; $display("FAIL bp_stall_hold got we=%0h addr=%0d data=%0h exp we=1 addr=1 data=0", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    bus.fb_ready = 1'b1;
    nw = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bus.fb_we === 1'b1 && nw < 10) begin
        tests++;
        if (bus.fb_addr !== ref_addr(nw * 7 + 1, nw * 3) || bus.fb_data !== 3'(nw)) begin
          fails++; $display("FAIL bp_write n=%0d got addr=%0d data=%0h exp addr=%0d data=%0h", nw, bus.fb_addr, bus.fb_data, ref_addr(nw * 7 + 1, nw * 3), 3'(nw));
        end
        nw++;
      end
      step();
    end
    tests++; if (nw !== 9) begin fails++; $display("FAIL bp_write_count got=%0d exp=9", nw); end
  endtask

  task automatic test_drop();
    int          nw;
    int          sent;
    logic [16:0] last_a;
    logic [2:0]  last_d;
    logic        took;
    bus.fb_ready = 1'b1;
    nw = 0; last_a = '0; last_d = '0;
    for (int k = 0; k < 9; k++) begin
      bus.in_valid = (k < 3);
      case (k)
        0: begin bus.in_x = 9'd320; bus.in_y = 8'd0;   bus.in_c = 3'd1; end
        1: begin bus.in_x = 9'd0;   bus.in_y = 8'd240; bus.in_c = 3'd2; end
        default: begin bus.in_x = 9'd319; bus.in_y = 8'd239; bus.in_c = 3'd3; end
      endcase
      if (bus.fb_we === 1'b1) begin nw++; last_a = bus.fb_addr; last_d = bus.fb_data; end
      step();
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.drop_count !== 8'd2) begin fails++; $display("FAIL drop_two got=%0d exp=2", bus.drop_count); end
    tests++; if (nw !== 1) begin fails++; $display("FAIL drop_write_count got=%0d exp=1", nw); end
    tests++;
    if (last_a !== 17'd76799 || last_d !== 3'd3) begin
      fails++; $display("FAIL drop_corner got addr=%0d data=%0h exp addr=76799 data=3", last_a, last_d);
    end
    sent = 0; nw = 0;
    for (int cyc = 0; cyc < 400 && sent < 260; cyc++) begin
      bus.in_valid = 1'b1;
      if (sent[0]) begin bus.in_x = 9'd5;   bus.in_y = 8'd250; end
      else         begin bus.in_x = 9'd400; bus.in_y = 8'd10;  end
      bus.in_c = 3'd7;
      if (bus.fb_we === 1'b1) nw++;
      took = bus.in_ready;
      step();
      if (took) sent++;
    end
    bus.in_valid = 1'b0;
    repeat (4) begin
      if (bus.fb_we === 1'b1) nw++;
      step();
    end
    tests++; if (sent !== 260) begin fails++; $display("FAIL drop_sent got=%0d exp=260", sent); end
    tests++; if (bus.drop_count !== 8'd255) begin fails++; $display("FAIL drop_saturate got=%0d exp=255", bus.drop_count); end
    tests++; if (nw !== 0) begin fails++; $display("FAIL drop_no_write got=%0d exp=0", nw); end
  endtask

  task automatic test_clear();
    int          nw;
    int          n_bad;
    int          first_bad;
    int          n_stall_bad;
    int          done_cnt;
    int          done_at;
    int          last_w;
    logic        pend;
    logic [16:0] s_addr;
    logic [2:0]  s_data;
    logic [16:0] exp_a;
    logic [2:0]  exp_d;
    bus.fb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_x = 9'(k + 100); bus.in_y = 8'(k + 7); bus.in_c = 3'(k + 4);
      bus.clear_req = (k == 2); bus.clear_color = 3'b010;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL clr_queue_ready k=%0d got=%0h exp=1", k, bus.in_ready); end
      step();
    end
    bus.in_valid = 1'b0; bus.clear_req = 1'b0; bus.clear_color = 3'b111;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL clr_drain_ready got=%0h exp=0", bus.in_ready); end
    nw = 0; n_bad = 0; first_bad = -1; n_stall_bad = 0; done_cnt = 0; done_at = -1; last_w = -1;
    pend = 1'b0; s_addr = '0; s_data = '0;
    for (int cyc = 0; cyc < 90000 && done_at < 0; cyc++) begin
      if (bus.clear_done === 1'b1) begin done_cnt++; done_at = cyc; end
      if (pend && !(bus.fb_we === 1'b1 && bus.fb_addr === s_addr && bus.fb_data === s_data)) n_stall_bad++;
      bus.fb_ready = (nw < 4003) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.fb_we === 1'b1 && bus.fb_ready) begin
        if (nw < 3) begin exp_a = ref_addr(nw + 100, nw + 7); exp_d = 3'(nw + 4); end
        else        begin exp_a = 17'(nw - 3);                exp_d = 3'b010;     end
        if (bus.fb_addr !== exp_a || bus.fb_data !== exp_d) begin
          n_bad++; if (first_bad < 0) first_bad = nw;
        end
        nw++; last_w = cyc;
      end
      pend = (bus.fb_we === 1'b1) && !bus.fb_ready;
      s_addr = bus.fb_addr; s_data = bus.fb_data;
      step();
    end
    tests++; if (nw !== 76803) begin fails++; $display("FAIL clr_write_count got=%0d exp=76803", nw); end
    tests++; if (n_bad !== 0) begin fails++; $display("FAIL clr_sequence got %0d bad writes (first at %0d) exp 0", n_bad, first_bad); end
    tests++; if (n_stall_bad !== 0) begin fails++; $display("FAIL clr_stall_stable got %0d unstable cycles exp 0", n_stall_bad); end
    tests++; if (done_at !== last_w + 1) begin fails++; $display("FAIL clr_done_timing got cycle=%0d exp=%0d", done_at, last_w + 1); end
    tests++;
    if (bus.clear_done !== 1'b0 || bus.fb_we !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL clr_after_done got done=%0h we=%0h ready=%0h exp done=0 we=0 ready=1", bus.clear_done, bus.fb_we, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic found;
    bus.fb_ready = 1'b1;
    bus.clear_req = 1'b1; bus.clear_color = 3'b101;
    step();
    bus.clear_req = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      if (bus.fb_we === 1'b1 && bus.fb_addr === 17'd1000) found = 1'b1;
      else step();
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL rmc_reach_1000 got=%0h exp=1 (timeout)", found); end
    reset = 1'b1;
    step();
    tests++;
    if (bus.fb_we !== 1'b0 || bus.drop_count !== 8'd0 || bus.fb_addr !== 17'd0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL rmc_reset got we=%0h drop=%0d addr=%0d ready=%0h exp we=0 drop=0 addr=0 ready=0", bus.fb_we, bus.drop_count, bus.fb_addr, bus.in_ready);
    end
    reset = 1'b0;
    step();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rmc_ready_after got=%0h exp=1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_x = 9'd5; bus.in_y = 8'd1; bus.in_c = 3'd6;
    step();
    bus.in_valid = 1'b0;
    step();
    tests++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd325 || bus.fb_data !== 3'd6) begin
      fails++; $display("FAIL rmc_stream got we=%0h addr=%0d data=%0h exp we=1 addr=325 data=6", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    step();
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_c = '0;
    bus.clear_req = 1'b0; bus.clear_color = '0; bus.fb_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
